bram_save_sequencer: RTL

//  Sequences transfers of the PCE backup RAM image between the dual-port backup RAM and the HPS SD

---
 rtl/bram_save_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bram_save_sequencer.sv
// -----------------------------------------------------------------------------
// bram_save_sequencer
//
// Moves the PCE backup RAM image between the dual-port backup RAM and the HPS
// SD block interface. Each sector is one sd_rd/sd_wr request answered by an
// sd_ack pulse. Start sources are manual load, manual save, auto-load after a
// cart download and autosave when the OSD opens. A separate 4-cycle format
// sequence writes the HUBM header words through fmt_*.
//
// Ports
//   clk_sys      in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high
//   bk_ena       in   1      writable save image mounted; gates every start
//   load_req     in   1      level; rising edge requests a load
//   save_req     in   1      level; rising edge requests a save
//   dl_done      in   1      pulse at the end of a cart download
//   img_nonzero  in   1      mounted image size is non-zero
//   autosave_en  in   1      autosave option
//   osd_open     in   1      OSD visible
//   bram_we      in   1      core write strobe to backup RAM
//   format_req   in   1      level; rising edge requests a format
//   sd_ack       in   1      HPS sector handshake
//   sd_lba       out  LBA_W  current sector number
//   sd_rd        out  1      sector read request (SD -> RAM)
//   sd_wr        out  1      sector write request (RAM -> SD)
//   busy         out  1      image transfer in progress
//   loading      out  1      load in progress (holds the core in reset)
//   pending      out  1      backup RAM holds unsaved writes
//   fmt_we       out  1      format write strobe
//   fmt_addr     out  2      format word address
//   fmt_data     out  16     format word
// -----------------------------------------------------------------------------
module bram_save_sequencer #(
  parameter int SECTORS = 16,
  parameter int LBA_W   = 32
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             bk_ena,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             dl_done,
  input  logic             img_nonzero,
  input  logic             autosave_en,
  input  logic             osd_open,
  input  logic             bram_we,
  input  logic             format_req,
  input  logic             sd_ack,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             busy,
  output logic             loading,
  output logic             pending,
  output logic             fmt_we,
  output logic [1:0]       fmt_addr,
  output logic [15:0]      fmt_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_FMT} state_t;

  localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(SECTORS - 1);

  // HUBM header words, one per format address.
  function automatic logic [15:0] fmt_word(input logic [1:0] a);
    case (a)
      2'd0:    fmt_word = 16'h5548;
      2'd1:    fmt_word = 16'h4D42;
      2'd2:    fmt_word = 16'h8800;
      default: fmt_word = 16'h8010;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [LBA_W-1:0] sd_lba_q, sd_lba_d;
  logic             sd_rd_q, sd_rd_d;
  logic             sd_wr_q, sd_wr_d;
  logic             busy_q, busy_d;
  logic             loading_q, loading_d;
  logic             pending_q, pending_d;
  logic             fmt_we_q, fmt_we_d;
  logic [1:0]       fmt_addr_q, fmt_addr_d;
  logic [15:0]      fmt_data_q, fmt_data_d;
  logic             fmt_pend_q, fmt_pend_d;

  // Edge-detect history. These reset to 1 so that a level already high when
  // reset releases is not mistaken for a fresh request.
  logic load_hist_q, save_hist_q, fmt_hist_q, ack_hist_q, auto_hist_q;

  logic load_rise, save_rise, fmt_rise, ack_rise, ack_fall;
  logic auto_cond, auto_rise;
  logic start, is_load;

  assign load_rise = load_req & ~load_hist_q;
  assign save_rise = save_req & ~save_hist_q;
  assign fmt_rise  = format_req & ~fmt_hist_q;
  assign ack_rise  = sd_ack & ~ack_hist_q;
  assign ack_fall  = ~sd_ack & ack_hist_q;
  assign auto_cond = pending_q & osd_open & autosave_en;
  assign auto_rise = auto_cond & ~auto_hist_q;

  always_comb begin
    state_d    = state_q;
    sd_lba_d   = sd_lba_q;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    busy_d     = busy_q;
    loading_d  = loading_q;
    pending_d  = pending_q;
    fmt_we_d   = fmt_we_q;
    fmt_addr_d = fmt_addr_q;
    fmt_data_d = fmt_data_q;
    fmt_pend_d = fmt_pend_q;
    start      = 1'b0;
    is_load    = 1'b0;

    // A format request outside IDLE is remembered and served first thing
    // once the sequencer is idle again.
    if (fmt_rise && state_q != ST_IDLE) begin
      fmt_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fmt_pend_q || fmt_rise) begin
          state_d    = ST_FMT;
          fmt_pend_d = 1'b0;
          fmt_we_d   = 1'b1;
          fmt_addr_d = 2'd0;
          fmt_data_d = fmt_word(2'd0);
        end else if (bk_ena) begin
          // Priority chain; anything lower in the same cycle is dropped.
          if (load_rise) begin
            start   = 1'b1;
            is_load = 1'b1;
          end else if (save_rise) begin
            start   = 1'b1;
          end else if (dl_done && img_nonzero) begin
            start   = 1'b1;
            is_load = 1'b1;
          end else if (auto_rise) begin
            start   = 1'b1;
          end
        end
        if (start) begin
          state_d   = ST_REQ;
          sd_lba_d  = '0;
          busy_d    = 1'b1;
          loading_d = is_load;
          sd_rd_d   = is_load;
          sd_wr_d   = ~is_load;
        end
      end

      ST_REQ: begin
        if (ack_rise) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        if (ack_fall) begin
          if (sd_lba_q == LAST_LBA) begin
            busy_d    = 1'b0;
            loading_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            // loading_q doubles as the direction of the running transfer.
            sd_lba_d = sd_lba_q + LBA_W'(1);
            sd_rd_d  = loading_q;
            sd_wr_d  = ~loading_q;
            state_d  = ST_REQ;
          end
        end
      end

      default: begin // ST_FMT
        if (fmt_addr_q == 2'd3) begin
          fmt_we_d   = 1'b0;
          fmt_addr_d = 2'd0;
          fmt_data_d = 16'h0000;
          state_d    = ST_IDLE;
        end else begin
          fmt_addr_d = fmt_addr_q + 2'd1;
          fmt_data_d = fmt_word(fmt_addr_q + 2'd1);
        end
      end
    endcase

    // A write in the same cycle as a transfer start keeps pending set.
    if (start) begin
      pending_d = 1'b0;
    end
    if (bram_we && bk_ena && !osd_open) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sd_lba_q    <= '0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      loading_q   <= 1'b0;
      pending_q   <= 1'b0;
      fmt_we_q    <= 1'b0;
      fmt_addr_q  <= 2'd0;
      fmt_data_q  <= 16'h0000;
      fmt_pend_q  <= 1'b0;
      load_hist_q <= 1'b1;
      save_hist_q <= 1'b1;
      fmt_hist_q  <= 1'b1;
      ack_hist_q  <= 1'b1;
      auto_hist_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sd_lba_q    <= sd_lba_d;
      sd_rd_q     <= sd_rd_d;
      sd_wr_q     <= sd_wr_d;
      busy_q      <= busy_d;
      loading_q   <= loading_d;
      pending_q   <= pending_d;
      fmt_we_q    <= fmt_we_d;
      fmt_addr_q  <= fmt_addr_d;
      fmt_data_q  <= fmt_data_d;
      fmt_pend_q  <= fmt_pend_d;
      load_hist_q <= load_req;
      save_hist_q <= save_req;
      fmt_hist_q  <= format_req;
      ack_hist_q  <= sd_ack;
      auto_hist_q <= auto_cond;
    end
  end

  assign sd_lba   = sd_lba_q;
  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign busy     = busy_q;
  assign loading  = loading_q;
  assign pending  = pending_q;
  assign fmt_we   = fmt_we_q;
  assign fmt_addr = fmt_addr_q;
  assign fmt_data = fmt_data_q;

endmodule
